// File: rtl/mips_core_pkg.sv
// Shared types and constants for the MIPS core front end.
package mips_core_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_VECTOR = 32'hBFC0_0000;
  localparam word_t HALT_ADDR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/mips_pc_redirect_buf.sv
// Holds a redirect that arrived while fetch was stalled and selects the
// redirect source for the next PC: a live redirect beats a held one.
// FETCH_MISALIGN_TRAP_EN: when defined, the target is passed through
// unmodified and misalignment is flagged; otherwise target[1:0] is cleared.
module mips_pc_redirect_buf
  import mips_core_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  capture,          // stalled in RUN with a redirect present
  input  logic  release_i,        // PC advances this cycle; held redirect is consumed
  input  logic  redirect_valid,
  input  word_t redirect_target,
  output logic  sel_valid,
  output word_t sel_target,
  output logic  misaligned
);

  logic  pending_valid_q, pending_valid_d;
  word_t pending_target_q, pending_target_d;
  word_t raw_target;

  // Pending register: newest redirect during a stall wins; cleared when taken
  always_comb begin
    pending_valid_d  = pending_valid_q;
    pending_target_d = pending_target_q;
    if (capture) begin
      pending_valid_d  = 1'b1;
      pending_target_d = redirect_target;
    end else if (release_i) begin
      pending_valid_d  = 1'b0;
    end
  end

  // Pending state flops, dropped on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_valid_q  <= 1'b0;
      pending_target_q <= '0;
    end else begin
      pending_valid_q  <= pending_valid_d;
      pending_target_q <= pending_target_d;
    end
  end

  // Priority mux: live redirect first, then the held one
  always_comb begin
    sel_valid  = redirect_valid | pending_valid_q;
    raw_target = redirect_valid ? redirect_target : pending_target_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    sel_target = raw_target;
    misaligned = sel_valid & (|raw_target[1:0]);
`else
    sel_target = raw_target & ~word_t'(32'h3);
    misaligned = 1'b0;
`endif
  end

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the RAM address, registers the
// returned word into IF/ID, applies decode redirects after the delay slot and
// halts when the PC reaches HALT_ADDR.
// Optional: FETCH_MISALIGN_TRAP_EN traps misaligned redirect targets (FAULT).
module mips_fetch_stage
  import mips_core_pkg::*;
#(
  parameter word_t RESET_VECTOR = mips_core_pkg::RESET_VECTOR,
  parameter word_t HALT_ADDR    = mips_core_pkg::HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] instr_q,
  output logic [31:0] pc_q,
  output logic        instr_valid,
  output logic        active,
  output logic        fault
);

  fetch_state_t state_q, state_d;
  word_t fetch_pc_q, fetch_pc_d;
  word_t ifid_instr_q, ifid_instr_d;
  word_t ifid_pc_q, ifid_pc_d;
  logic  ifid_valid_q, ifid_valid_d;

  logic  running, at_halt, advance, halt_now, trap;
  logic  sel_valid, misaligned;
  word_t sel_target;

  // Cycle qualifiers shared by FSM and datapath
  always_comb begin
    running  = (state_q == RUN);
    at_halt  = (fetch_pc_q == HALT_ADDR);
    advance  = running & ~stall & ~at_halt;
    halt_now = running & ~stall & at_halt;
    trap     = advance & misaligned;
  end

  mips_pc_redirect_buf u_redirect_buf (
    .clk             (clk),
    .rst             (reset),
    .capture         (running & stall & redirect_valid),
    .release_i       (advance),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .sel_valid       (sel_valid),
    .sel_target      (sel_target),
    .misaligned      (misaligned)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FSM next state: HALT and FAULT are sticky until reset
  always_comb begin
    state_d = state_q;
    if (halt_now)  state_d = HALT;
    else if (trap) state_d = FAULT;
  end

  // FSM outputs
  always_comb begin
    active = (state_q == RUN);
    fault  = (state_q == FAULT);
  end

  // PC and IF/ID next values; the delay-slot word is captured even on a trap
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    if (advance) begin
      ifid_instr_d = instr_readdata;
      ifid_pc_d    = fetch_pc_q;
      ifid_valid_d = ~trap;
      fetch_pc_d   = sel_valid ? sel_target : fetch_pc_q + 32'd4;
    end else if (halt_now) begin
      ifid_valid_d = 1'b0;
    end
  end

  // PC and IF/ID registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q   <= RESET_VECTOR;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign instr_address = fetch_pc_q;
  assign instr_q       = ifid_instr_q;
  assign pc_q          = ifid_pc_q;
  assign instr_valid   = ifid_valid_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage. The instruction RAM is modelled as
// word(addr) = addr ^ 32'h12345678 so every expected word is known up front.
module tb_mips_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] instr_address, instr_readdata, instr_q, pc_q;
  logic        instr_valid, active, fault;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  assign instr_readdata = ram_word(instr_address);

  mips_fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_address   (instr_address),
    .instr_readdata  (instr_readdata),
    .instr_q         (instr_q),
    .pc_q            (pc_q),
    .instr_valid     (instr_valid),
    .active          (active),
    .fault           (fault)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Async pulse placed between edges; reset state checked while asserted
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_addr"},   instr_address, 32'hBFC0_0000);
    chk({tag, "_valid"},  {31'd0, instr_valid}, 32'd0);
    chk({tag, "_active"}, {31'd0, active}, 32'd1);
    chk({tag, "_fault"},  {31'd0, fault}, 32'd0);
    chk({tag, "_pcq"},    pc_q, 32'd0);
    chk({tag, "_instrq"}, instr_q, 32'd0);
    #2 reset = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    #12 reset = 1'b0;
    tick(); tick(); tick();
    chk("prerun_addr", instr_address, 32'hBFC0_000C);

    do_reset("rst_mid");

    // Sequential fetch
    for (int k = 0; k < 4; k++) begin
      tick();
      a = 32'hBFC0_0000 + 32'(4 * k);
      chk($sformatf("seq%0d_pcq", k), pc_q, a);
      chk($sformatf("seq%0d_instr", k), instr_q, ram_word(a));
      chk($sformatf("seq%0d_valid", k), {31'd0, instr_valid}, 32'd1);
    end
    chk("seq_addr", instr_address, 32'hBFC0_0010);

    // Redirect with delay slot at pc=BFC00008
    do_reset("rst2");
    tick(); tick();
    chk("br_pre_addr", instr_address, 32'hBFC0_0008);
    redirect_valid = 1'b1; redirect_target = 32'hBFC0_0100;
    tick();
    redirect_valid = 1'b0;
    chk("br_slot_pcq", pc_q, 32'hBFC0_0008);
    chk("br_slot_instr", instr_q, ram_word(32'hBFC0_0008));
    chk("br_tgt_addr", instr_address, 32'hBFC0_0100);
    tick();
    chk("br_tgt_pcq", pc_q, 32'hBFC0_0100);
    chk("br_next_addr", instr_address, 32'hBFC0_0104);

    // Redirect arriving in the middle of a 3-cycle stall
    stall = 1'b1;
    tick();
    chk("st1_addr", instr_address, 32'hBFC0_0104);
    chk("st1_pcq", pc_q, 32'hBFC0_0100);
    redirect_valid = 1'b1; redirect_target = 32'hBFC0_0040;
    tick();
    redirect_valid = 1'b0;
    chk("st2_addr", instr_address, 32'hBFC0_0104);
    tick();
    chk("st3_addr", instr_address, 32'hBFC0_0104);
    chk("st3_valid", {31'd0, instr_valid}, 32'd1);
    chk("st3_pcq", pc_q, 32'hBFC0_0100);
    stall = 1'b0;
    tick();
    chk("strel_pcq", pc_q, 32'hBFC0_0104);
    chk("strel_addr", instr_address, 32'hBFC0_0040);
    tick();
    chk("strel2_pcq", pc_q, 32'hBFC0_0040);
    chk("strel2_addr", instr_address, 32'hBFC0_0044);

    // Later redirect in the same stall overwrites the held one
    stall = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'hBFC0_0200;
    tick();
    redirect_target = 32'hBFC0_0300;
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    tick();
    chk("ovw_pcq", pc_q, 32'hBFC0_0044);
    chk("ovw_addr", instr_address, 32'hBFC0_0300);

    // Misaligned redirect target
    redirect_valid = 1'b1; redirect_target = 32'hBFC0_0102;
    tick();
    redirect_valid = 1'b0;
    chk("mis_slot_pcq", pc_q, 32'hBFC0_0300);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_addr", instr_address, 32'hBFC0_0102);
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_active", {31'd0, active}, 32'd0);
    chk("mis_valid", {31'd0, instr_valid}, 32'd0);
`else
    chk("mis_addr", instr_address, 32'hBFC0_0100);
    chk("mis_fault", {31'd0, fault}, 32'd0);
    chk("mis_active", {31'd0, active}, 32'd1);
    chk("mis_valid", {31'd0, instr_valid}, 32'd1);
`endif

    // jr r0: slot captured, then pc=0, then halt
    do_reset("rst3");
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h0;
    tick();
    redirect_valid = 1'b0;
    chk("jr_slot_pcq", pc_q, 32'hBFC0_0004);
    chk("jr_addr", instr_address, 32'h0);
    chk("jr_active", {31'd0, active}, 32'd1);
    redirect_valid = 1'b1; redirect_target = 32'hBFC0_0500;
    tick();
    redirect_valid = 1'b0;
    chk("halt_active", {31'd0, active}, 32'd0);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_addr", instr_address, 32'h0);
    chk("halt_pcq", pc_q, 32'hBFC0_0004);
    for (int k = 0; k < 10; k++) begin
      redirect_valid = k[0];
      redirect_target = 32'hBFC0_0600;
      tick();
      chk($sformatf("hold%0d_addr", k), instr_address, 32'h0);
      chk($sformatf("hold%0d_act", k), {31'd0, active}, 32'd0);
      chk($sformatf("hold%0d_pcq", k), pc_q, 32'hBFC0_0004);
      chk($sformatf("hold%0d_val", k), {31'd0, instr_valid}, 32'd0);
    end
    redirect_valid = 1'b0;

    do_reset("rst4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
